// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 16-bit CPU: owns the instruction register,
// sequences fetch/decode/execute/memory/writeback and counts retired instructions.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | instruction memory being loaded (or just reset); no fetch
// S_FETCH  | latch instruction into ir, advance PC by one
// S_DECODE | resolve JMP/HALT/NOP immediately, everything else to EXEC
// S_EXEC   | ALU operation; BEQ resolves its branch here
// S_MEM    | data memory strobe held until mem_ready or timeout
// S_WB     | register file write (ALU result or load data)
// S_HALT   | terminal until pc_reset
module cpu_control_fsm #(
  parameter int CNT_W        = 16,
  parameter int MEM_WAIT_MAX = 8
) (
  input  logic             clk,
  input  logic             pc_reset,
  input  logic             load_instruction,
  input  logic [15:0]      instruction,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic [15:0]      ir,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [3:0]       read_reg1,
  output logic [3:0]       read_reg2,
  output logic [3:0]       write_reg,
  output logic             reg_write,
  output logic [2:0]       alu_op,
  output logic             alu_src,
  output logic [15:0]      imm,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             mem_fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] PC_SRC_INC    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_next;

  logic [WAIT_W-1:0] wait_cnt;
  logic              load_ir;
  logic              retire;
  logic              set_fault;
  logic              wait_inc;
  logic              wait_clr;

  logic [3:0] opcode;
  logic       is_rtype;
  logic       is_addi;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_jmp;
  logic       is_halt;
  logic       is_mem;
  logic       is_nop;

  assign opcode   = ir[15:12];
  assign is_rtype = (opcode <= 4'h5);
  assign is_addi  = (opcode == 4'h6);
  assign is_lw    = (opcode == 4'h8);
  assign is_sw    = (opcode == 4'h9);
  assign is_beq   = (opcode == 4'hA);
  assign is_jmp   = (opcode == 4'hB);
  assign is_halt  = (opcode == 4'hF);
  assign is_mem   = is_lw | is_sw;
  assign is_nop   = ~(is_rtype | is_addi | is_mem | is_beq | is_jmp | is_halt);

  // SW and BEQ compare/store rd, so the second read port points at rd for them.
  assign read_reg1 = ir[7:4];
  assign read_reg2 = (is_sw | is_beq) ? ir[11:8] : ir[3:0];
  assign write_reg = ir[11:8];
  assign imm       = is_jmp ? {4'h0, ir[11:0]} : {{12{ir[3]}}, ir[3:0]};

  always_ff @(posedge clk) begin
    if (pc_reset) begin
      state       <= S_IDLE;
      ir          <= '0;
      instr_count <= '0;
      mem_fault   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state <= state_next;
      if (load_ir)
        ir <= instruction;
      if (retire)
        instr_count <= instr_count + 1'b1;
      if (set_fault)
        mem_fault <= 1'b1;
      if (wait_clr)
        wait_cnt <= '0;
      else if (wait_inc)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    load_ir    = 1'b0;
    retire     = 1'b0;
    set_fault  = 1'b0;
    wait_inc   = 1'b0;
    wait_clr   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_INC;
    reg_write  = 1'b0;
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;

    case (state)
      S_IDLE: begin
        if (!load_instruction)
          state_next = S_FETCH;
      end

      S_FETCH: begin
        if (load_instruction) begin
          state_next = S_IDLE;
        end else begin
          load_ir    = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_jmp) begin
          pc_write   = 1'b1;
          pc_src     = PC_SRC_JUMP;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (is_halt) begin
          retire     = 1'b1;
          state_next = S_HALT;
        end else if (is_nop) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_rtype) begin
          alu_op     = opcode[2:0];
          state_next = S_WB;
        end else if (is_addi) begin
          alu_src    = 1'b1;
          state_next = S_WB;
        end else if (is_mem) begin
          alu_src    = 1'b1;
          state_next = S_MEM;
        end else if (is_beq) begin
          alu_op = ALU_SUB;
          if (alu_zero) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_BRANCH;
          end
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_FETCH;
        end
      end

      S_MEM: begin
        mem_read  = is_lw;
        mem_write = is_sw;
        alu_src   = 1'b1;
        if (mem_ready) begin
          wait_clr = 1'b1;
          if (is_lw) begin
            state_next = S_WB;
          end else begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
        end else if (wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1)) begin
          // Timed-out access is abandoned without retiring.
          set_fault  = 1'b1;
          wait_clr   = 1'b1;
          state_next = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: per-instruction cycle scripts derived from the
// instruction-level latency and strobe rules, checked every cycle, plus literals.
module tb_cpu_control_fsm;

  localparam int CNT_W = 16;
  localparam int MWM   = 8;

  logic        clk;
  logic        pc_reset;
  logic        load_instruction;
  logic [15:0] instruction;
  logic        alu_zero;
  logic        mem_ready;
  logic [15:0] ir;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [3:0]  read_reg1;
  logic [3:0]  read_reg2;
  logic [3:0]  write_reg;
  logic        reg_write;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic [15:0] imm;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        halted;
  logic        mem_fault;
  logic [CNT_W-1:0] instr_count;

  cpu_control_fsm #(.CNT_W(CNT_W), .MEM_WAIT_MAX(MWM)) dut (
    .clk              (clk),
    .pc_reset         (pc_reset),
    .load_instruction (load_instruction),
    .instruction      (instruction),
    .alu_zero         (alu_zero),
    .mem_ready        (mem_ready),
    .ir               (ir),
    .pc_write         (pc_write),
    .pc_src           (pc_src),
    .read_reg1        (read_reg1),
    .read_reg2        (read_reg2),
    .write_reg        (write_reg),
    .reg_write        (reg_write),
    .alu_op           (alu_op),
    .alu_src          (alu_src),
    .imm              (imm),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_to_reg       (mem_to_reg),
    .halted           (halted),
    .mem_fault        (mem_fault),
    .instr_count      (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // strobe tallies sampled on the compare edge
  int c_pw = 0;
  int c_rw = 0;
  int c_rd = 0;
  int c_wr = 0;

  // architectural model state
  logic [15:0] m_ir;
  logic [15:0] m_count;
  bit          m_fault;
  bit          m_halted;
  bit          m_idle;

  // expected outputs for the cycle being driven
  bit          e_pc_write;
  logic [1:0]  e_pc_src;
  bit          e_reg_write;
  logic [2:0]  e_alu_op;
  bit          e_alu_src;
  bit          e_mem_read;
  bit          e_mem_write;
  bit          e_mem_to_reg;
  bit          e_halted;
  bit          e_fault;
  logic [15:0] e_ir;
  logic [15:0] e_count;

  function automatic logic [27:0] fields(input logic [15:0] x);
    logic [3:0]  rr2;
    logic [15:0] im;
    rr2 = (x[15:12] == 4'h9 || x[15:12] == 4'hA) ? x[11:8] : x[3:0];
    im  = (x[15:12] == 4'hB) ? {4'h0, x[11:0]} : {{12{x[3]}}, x[3:0]};
    return {x[7:4], rr2, x[11:8], im};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: actual %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    check("ctrl", 32'({pc_write, pc_src, reg_write, alu_op, alu_src, mem_read, mem_write, mem_to_reg}),
          32'({e_pc_write, e_pc_src, e_reg_write, e_alu_op, e_alu_src, e_mem_read, e_mem_write, e_mem_to_reg}));
    check("ir", 32'(ir), 32'(e_ir));
    check("fields", 32'({read_reg1, read_reg2, write_reg, imm}), 32'(fields(e_ir)));
    check("count", 32'(instr_count), 32'(e_count));
    check("status", 32'({halted, mem_fault}), 32'({e_halted, e_fault}));
  endtask

  task automatic exp_default();
    e_pc_write   = 1'b0;
    e_pc_src     = 2'b00;
    e_reg_write  = 1'b0;
    e_alu_op     = 3'b000;
    e_alu_src    = 1'b0;
    e_mem_read   = 1'b0;
    e_mem_write  = 1'b0;
    e_mem_to_reg = 1'b0;
    e_halted     = m_halted;
    e_fault      = m_fault;
    e_ir         = m_ir;
    e_count      = m_count;
  endtask

  task automatic model_reset();
    m_ir     = 16'h0;
    m_count  = 16'h0;
    m_fault  = 1'b0;
    m_halted = 1'b0;
    m_idle   = 1'b1;
  endtask

  // Drive one cycle from posedge+1; compare on the falling edge.
  task automatic step(input bit ld, input logic [15:0] ins, input bit rdy, input bit z,
                      input bit rst, input bit chk);
    load_instruction = ld;
    instruction      = ins;
    mem_ready        = rdy;
    alu_zero         = z;
    pc_reset         = rst;
    @(negedge clk);
    if (chk) compare_all();
    if (pc_write)  c_pw++;
    if (reg_write) c_rw++;
    if (mem_read)  c_rd++;
    if (mem_write) c_wr++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_cycle();
    step(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
    model_reset();
  endtask

  // n cycles with load held, then one release cycle; the next cycle is a fetch.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_default();
      step(1'b1, 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
    end
    exp_default();
    step(1'b0, 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
    m_idle = 1'b0;
  endtask

  task automatic divert();
    exp_default();
    step(1'b1, 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
    m_idle = 1'b1;
    idle(int'($urandom_range(0, 2)));
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      exp_default();
      step(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
    end
  endtask

  // One instruction from its fetch to the cycle before the next fetch.
  // waits >= MWM means mem_ready never arrives; abort_at >= 0 resets on that cycle.
  task automatic run_instr(input logic [15:0] ins, input int waits, input bit z, input int abort_at);
    logic [3:0] op;
    bit is_r, is_addi, is_lw, is_sw, is_beq, is_jmp, is_halt, is_nop, is_mem, fault;
    int nmem, len;
    bit ld, rdy, zz, rst;
    logic [15:0] drv;
    op      = ins[15:12];
    is_r    = (op <= 4'h5);
    is_addi = (op == 4'h6);
    is_lw   = (op == 4'h8);
    is_sw   = (op == 4'h9);
    is_beq  = (op == 4'hA);
    is_jmp  = (op == 4'hB);
    is_halt = (op == 4'hF);
    is_mem  = is_lw || is_sw;
    is_nop  = !(is_r || is_addi || is_mem || is_beq || is_jmp || is_halt);
    fault   = is_mem && (waits >= MWM);
    nmem    = is_mem ? (fault ? MWM : waits + 1) : 0;
    if (is_jmp || is_nop || is_halt) len = 2;
    else if (is_beq)                 len = 3;
    else if (is_mem)                 len = 3 + nmem + ((is_lw && !fault) ? 1 : 0);
    else                             len = 4;

    for (int k = 0; k < len; k++) begin
      exp_default();
      ld  = (k == 0) ? 1'b0 : 1'($urandom);
      rdy = 1'($urandom);
      zz  = 1'($urandom);
      drv = (k == 0) ? ins : 16'($urandom);
      rst = (k == abort_at);
      if (k == 0) e_pc_write = 1'b1;
      if (k == 1 && is_jmp) begin
        e_pc_write = 1'b1;
        e_pc_src   = 2'b10;
      end
      if (k == 2) begin
        if (is_r) e_alu_op = op[2:0];
        if (is_addi || is_mem) e_alu_src = 1'b1;
        if (is_beq) begin
          e_alu_op = 3'b001;
          zz = z;
          if (z) begin
            e_pc_write = 1'b1;
            e_pc_src   = 2'b01;
          end
        end
      end
      if (is_mem && k >= 3 && k < 3 + nmem) begin
        e_mem_read  = is_lw;
        e_mem_write = is_sw;
        e_alu_src   = 1'b1;
        rdy = (!fault && k == 3 + nmem - 1);
      end
      if (k == len - 1 && (is_r || is_addi || (is_lw && !fault))) begin
        e_reg_write  = 1'b1;
        e_mem_to_reg = is_lw;
      end
      step(ld, drv, rdy, zz, rst, 1'b1);
      if (rst) begin
        model_reset();
        return;
      end
      if (k == 0) m_ir = ins;
      if (k == len - 1) begin
        if (fault) m_fault = 1'b1;
        else       m_count = m_count + 16'd1;
        if (fault || is_halt) m_halted = 1'b1;
      end
    end
  endtask

  initial begin
    int pw0, rw0, rd0, wr0;
    logic [3:0]  op;
    logic [15:0] ins;
    int waits, abort_at;

    load_instruction = 1'b1;
    instruction      = 16'h0;
    alu_zero         = 1'b0;
    mem_ready        = 1'b0;
    pc_reset         = 1'b1;
    model_reset();
    exp_default();
    @(posedge clk);
    #1;
    step(1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);

    rw0 = c_rw;
    run_instr(16'h0123, 0, 1'b0, -1);
    check("add_reg_write_cycles", 32'(c_rw - rw0), 32'd1);
    check("add_read_reg1", 32'(read_reg1), 32'd2);
    check("add_read_reg2", 32'(read_reg2), 32'd3);
    check("add_write_reg", 32'(write_reg), 32'd1);
    check("add_count", 32'(instr_count), 32'd1);

    rd0 = c_rd;
    run_instr(16'h8215, 2, 1'b0, -1);
    check("lw_mem_read_cycles", 32'(c_rd - rd0), 32'd3);
    check("lw_imm_pos", 32'(imm), 32'h0005);
    run_instr(16'h821F, 0, 1'b0, -1);
    check("lw_imm_neg", 32'(imm), 32'hFFFF);

    pw0 = c_pw;
    run_instr(16'hA12E, 0, 1'b1, -1);
    check("beq_taken_pc_writes", 32'(c_pw - pw0), 32'd2);
    check("beq_imm", 32'(imm), 32'hFFFE);
    pw0 = c_pw;
    run_instr(16'hA12E, 0, 1'b0, -1);
    check("beq_not_taken_pc_writes", 32'(c_pw - pw0), 32'd1);

    pw0 = c_pw;
    run_instr(16'hB3A5, 0, 1'b0, -1);
    check("jmp_pc_writes", 32'(c_pw - pw0), 32'd2);
    check("jmp_imm", 32'(imm), 32'h03A5);

    run_instr(16'hF000, 0, 1'b0, -1);
    halt_hold(4);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_count", 32'(instr_count), 32'd7);

    reset_cycle();
    idle(0);
    divert();
    wr0 = c_wr;
    run_instr(16'h9000, MWM, 1'b0, -1);
    check("sw_timeout_write_cycles", 32'(c_wr - wr0), 32'(MWM));
    check("sw_timeout_fault", 32'(mem_fault), 32'd1);
    check("sw_timeout_halted", 32'(halted), 32'd1);
    halt_hold(3);
    reset_cycle();
    check("reset_clears_fault", 32'({mem_fault, halted}), 32'd0);
    idle(1);

    run_instr(16'h9123, 5, 1'b0, 5);
    idle(1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 8) divert();
      op = 4'($urandom);
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
      ins      = {op, 12'($urandom)};
      waits    = ($urandom_range(0, 99) < 10) ? MWM + int'($urandom_range(0, 1))
                                              : int'($urandom_range(0, 3));
      abort_at = ($urandom_range(0, 99) < 5) ? int'($urandom_range(0, 4)) : -1;
      run_instr(ins, waits, 1'($urandom), abort_at);
      if (m_idle) begin
        idle(int'($urandom_range(0, 2)));
      end else if (m_halted) begin
        halt_hold(3);
        reset_cycle();
        idle(int'($urandom_range(0, 2)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
